descriptor_input_arbiter: RTL and testbench

// Merges descriptor streams from 4 ingress ports into the single descriptor stream feeding

---
 rtl/descriptor_input_arbiter.sv | 175 +++++++++++++++++
 tb/tb_descriptor_input_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/descriptor_input_arbiter.sv
// Four-port descriptor merger: per-port FIFOs, round-robin issue of one descriptor per cycle,
// saturating drop counter and a drain/pause handshake for lookup-table updates.
module descriptor_input_arbiter #(
    parameter int FIFO_AW      = 2,
    parameter int DRAIN_CYCLES = 4,
    parameter int DATA_W       = 72
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [DATA_W-1:0] iv_descriptor_p0,
    input  logic [DATA_W-1:0] iv_descriptor_p1,
    input  logic [DATA_W-1:0] iv_descriptor_p2,
    input  logic [DATA_W-1:0] iv_descriptor_p3,
    input  logic              i_descriptor_wr_p0,
    input  logic              i_descriptor_wr_p1,
    input  logic              i_descriptor_wr_p2,
    input  logic              i_descriptor_wr_p3,
    output logic [DATA_W-1:0] ov_descriptor,
    output logic              o_descriptor_wr,
    input  logic              i_cfg_pause_req,
    output logic              o_cfg_pause_ack,
    output logic [15:0]       ov_drop_cnt,
    output logic              o_idle
);
    localparam int NPORT = 4;
    localparam int DEPTH = 1 << FIFO_AW;

    typedef enum logic [1:0] {RUN, DRAIN, PAUSE} state_t;

    logic [DATA_W-1:0] din [NPORT];
    logic [NPORT-1:0]  wr;
    logic [DATA_W-1:0] mem [NPORT][DEPTH];
    logic [FIFO_AW:0]  wptr [NPORT];
    logic [FIFO_AW:0]  rptr [NPORT];
    logic [NPORT-1:0]  empty, full, pop, push, drop;
    logic [1:0]        last_grant;
    logic [1:0]        scan_idx;
    logic              grant_vld_p0;
    logic [1:0]        grant_idx_p0;
    logic              wr_p1;
    logic [DATA_W-1:0] desc_p1;
    logic [15:0]       drop_cnt;
    state_t            state;
    logic [3:0]        drain_cnt;
    logic              ack;

    function automatic logic [2:0] count_drops(input logic [NPORT-1:0] d);
        count_drops = 3'(d[0]) + 3'(d[1]) + 3'(d[2]) + 3'(d[3]);
    endfunction

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [2:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + 17'(b);
        sat_add = sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    assign din[0] = iv_descriptor_p0;
    assign din[1] = iv_descriptor_p1;
    assign din[2] = iv_descriptor_p2;
    assign din[3] = iv_descriptor_p3;
    assign wr     = {i_descriptor_wr_p3, i_descriptor_wr_p2, i_descriptor_wr_p1, i_descriptor_wr_p0};

    always_comb begin
        for (int p = 0; p < NPORT; p++) begin
            empty[p] = (wptr[p] == rptr[p]);
            full[p]  = (wptr[p][FIFO_AW] != rptr[p][FIFO_AW]) &&
                       (wptr[p][FIFO_AW-1:0] == rptr[p][FIFO_AW-1:0]);
        end
    end

    // Stage p0: round-robin pick starting one past the last granted port
    always_comb begin
        grant_vld_p0 = 1'b0;
        grant_idx_p0 = '0;
        scan_idx     = '0;
        if (state == RUN && !i_cfg_pause_req) begin
            for (int k = 1; k <= NPORT; k++) begin
                scan_idx = last_grant + 2'(k);
                if (!grant_vld_p0 && !empty[scan_idx]) begin
                    grant_vld_p0 = 1'b1;
                    grant_idx_p0 = scan_idx;
                end
            end
        end
    end

    // A full FIFO still accepts a write when its head is popped in the same cycle
    always_comb begin
        for (int p = 0; p < NPORT; p++) begin
            pop[p]  = grant_vld_p0 && (grant_idx_p0 == 2'(p));
            push[p] = wr[p] && (!full[p] || pop[p]);
            drop[p] = wr[p] && full[p] && !pop[p];
        end
    end

    always_ff @(posedge i_clk) begin
        for (int p = 0; p < NPORT; p++) begin
            if (push[p]) mem[p][wptr[p][FIFO_AW-1:0]] <= din[p];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int p = 0; p < NPORT; p++) begin
                wptr[p] <= '0;
                rptr[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NPORT; p++) begin
                if (push[p]) wptr[p] <= wptr[p] + 1'b1;
                if (pop[p])  rptr[p] <= rptr[p] + 1'b1;
            end
        end
    end

    // Stage p1: registered merged output, zeroed when nothing is issued
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_p1      <= 1'b0;
            desc_p1    <= '0;
            last_grant <= 2'd3;
            drop_cnt   <= '0;
        end else begin
            wr_p1    <= grant_vld_p0;
            desc_p1  <= grant_vld_p0 ? mem[grant_idx_p0][rptr[grant_idx_p0][FIFO_AW-1:0]] : '0;
            drop_cnt <= sat_add(drop_cnt, count_drops(drop));
            if (grant_vld_p0) last_grant <= grant_idx_p0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= RUN;
            drain_cnt <= '0;
            ack       <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (i_cfg_pause_req) begin
                        state     <= DRAIN;
                        drain_cnt <= 4'(DRAIN_CYCLES);
                    end
                end
                DRAIN: begin
                    if (!i_cfg_pause_req) begin
                        state <= RUN;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                        if (drain_cnt == 4'd1) begin
                            state <= PAUSE;
                            ack   <= 1'b1;
                        end
                    end
                end
                PAUSE: begin
                    if (!i_cfg_pause_req) begin
                        state <= RUN;
                        ack   <= 1'b0;
                    end
                end
                default: begin
                    state <= RUN;
                    ack   <= 1'b0;
                end
            endcase
        end
    end

    assign ov_descriptor   = desc_p1;
    assign o_descriptor_wr = wr_p1;
    assign o_cfg_pause_ack = ack;
    assign ov_drop_cnt     = drop_cnt;
    assign o_idle          = (&empty) && !wr_p1;

endmodule

// File: tb/tb_descriptor_input_arbiter.sv
// Bench for descriptor_input_arbiter: vector table of strobe patterns plus hand sequences,
// with a queue scoreboard checking every merged output in order.
module tb_descriptor_input_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [71:0] din [4];
    logic [3:0]  wr = '0;
    logic        req = 1'b0;
    logic [71:0] desc;
    logic        desc_wr;
    logic        ack;
    logic [15:0] drop_cnt;
    logic        idle;

    int          errors = 0;
    int          checks = 0;
    logic        mon_en = 1'b0;
    logic [71:0] expq [$];

    typedef struct {
        logic [3:0]      mask_a;
        logic [3:0]      mask_b;
        int              n;
        logic [3:0][7:0] exp_v;
    } vec_t;
    vec_t tbl [5];

    always #4 clk = ~clk;

    descriptor_input_arbiter dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .iv_descriptor_p0   (din[0]),
        .iv_descriptor_p1   (din[1]),
        .iv_descriptor_p2   (din[2]),
        .iv_descriptor_p3   (din[3]),
        .i_descriptor_wr_p0 (wr[0]),
        .i_descriptor_wr_p1 (wr[1]),
        .i_descriptor_wr_p2 (wr[2]),
        .i_descriptor_wr_p3 (wr[3]),
        .ov_descriptor      (desc),
        .o_descriptor_wr    (desc_wr),
        .i_cfg_pause_req    (req),
        .o_cfg_pause_ack    (ack),
        .ov_drop_cnt        (drop_cnt),
        .o_idle             (idle)
    );

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ports(input logic [3:0] mask, input logic [7:0] base);
        for (int p = 0; p < 4; p++) begin
            wr[p]  = mask[p];
            din[p] = mask[p] ? 72'(base + 8'(p)) : 72'h0;
        end
    endtask

    task automatic do_reset();
        wr  = '0;
        req = 1'b0;
        for (int p = 0; p < 4; p++) din[p] = '0;
        rst_n = 1'b0;
        expq.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
    endtask

    // Scoreboard: every issued descriptor must match the head of the expected queue
    initial begin
        logic [71:0] e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                checks++;
                if (desc_wr) begin
                    if (expq.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_out: got %0h expected no output", desc);
                    end else begin
                        e = expq.pop_front();
                        if (desc !== e) begin
                            errors++;
                            $display("FAIL out_order: got %0h expected %0h", desc, e);
                        end
                    end
                end else if (desc !== 72'h0) begin
                    errors++;
                    $display("FAIL desc_zero: got %0h expected 0", desc);
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        for (int p = 0; p < 4; p++) din[p] = '0;
        tbl[0] = '{4'b1111, 4'b0000, 4, {8'h04, 8'h03, 8'h02, 8'h01}};
        tbl[1] = '{4'b1010, 4'b0101, 4, {8'h11, 8'h04, 8'h13, 8'h02}};
        tbl[2] = '{4'b0001, 4'b0001, 2, {8'h00, 8'h00, 8'h11, 8'h01}};
        tbl[3] = '{4'b1000, 4'b1001, 3, {8'h00, 8'h14, 8'h11, 8'h04}};
        tbl[4] = '{4'b0011, 4'b1100, 4, {8'h14, 8'h13, 8'h02, 8'h01}};

        #2 rst_n = 1'b0;
        tick();
        tick();
        @(negedge clk);
        check("rst_wr", 72'(desc_wr), 72'h0);
        check("rst_desc", desc, 72'h0);
        check("rst_ack", 72'(ack), 72'h0);
        check("rst_drop", 72'(drop_cnt), 72'h0);
        check("rst_idle", 72'(idle), 72'h1);
        rst_n = 1'b1;
        mon_en = 1'b1;
        repeat (3) tick();

        // Single descriptor on p2: visible two cycles after its strobe
        wr[2] = 1'b1;
        din[2] = 72'hA5;
        expq.push_back(72'hA5);
        tick();
        wr = '0;
        din[2] = '0;
        @(negedge clk);
        check("lat_t1_wr", 72'(desc_wr), 72'h0);
        check("lat_t1_idle", 72'(idle), 72'h0);
        tick();
        @(negedge clk);
        check("lat_t2_wr", 72'(desc_wr), 72'h1);
        check("lat_t2_desc", desc, 72'hA5);
        repeat (4) tick();
        check("lat_idle", 72'(idle), 72'h1);

        for (int i = 0; i < 5; i++) begin
            do_reset();
            for (int j = 0; j < tbl[i].n; j++) expq.push_back(72'(tbl[i].exp_v[j]));
            set_ports(tbl[i].mask_a, 8'h01);
            tick();
            set_ports(tbl[i].mask_b, 8'h11);
            tick();
            set_ports(4'b0000, 8'h00);
            repeat (10) tick();
            check($sformatf("tbl%0d_drained", i), 72'(expq.size()), 72'h0);
            check($sformatf("tbl%0d_idle", i), 72'(idle), 72'h1);
            check($sformatf("tbl%0d_drop", i), 72'(drop_cnt), 72'h0);
        end

        // p1 burst against two queued descriptors on each other port
        for (int b = 6; b <= 8; b += 2) begin
            do_reset();
            expq.push_back(72'hA0); expq.push_back(72'hB0);
            expq.push_back(72'hC0); expq.push_back(72'hD0);
            expq.push_back(72'hA1); expq.push_back(72'hB1);
            expq.push_back(72'hC1); expq.push_back(72'hD1);
            expq.push_back(72'hB2); expq.push_back(72'hB3);
            expq.push_back(72'hB4); expq.push_back(72'hB5);
            wr = 4'b1101;
            din[0] = 72'hA0; din[2] = 72'hC0; din[3] = 72'hD0;
            tick();
            wr = 4'b1111;
            din[0] = 72'hA1; din[1] = 72'hB0; din[2] = 72'hC1; din[3] = 72'hD1;
            tick();
            wr = 4'b0010;
            din[0] = '0; din[2] = '0; din[3] = '0;
            for (int k = 1; k < b; k++) begin
                din[1] = 72'(8'hB0 + 8'(k));
                tick();
            end
            wr = '0;
            din[1] = '0;
            repeat (16) tick();
            check($sformatf("burst%0d_drop", b), 72'(drop_cnt), 72'(b - 6));
            check($sformatf("burst%0d_drained", b), 72'(expq.size()), 72'h0);
        end

        // Pause with three descriptors queued on p0
        do_reset();
        wr[0] = 1'b1; din[0] = 72'hE0; req = 1'b1;
        tick();
        din[0] = 72'hE1;
        tick();
        din[0] = 72'hE2;
        tick();
        wr = '0; din[0] = '0;
        tick();
        @(negedge clk);
        check("pause_ack_early", 72'(ack), 72'h0);
        tick();
        @(negedge clk);
        check("pause_ack_rise", 72'(ack), 72'h1);
        repeat (3) tick();
        check("pause_ack_hold", 72'(ack), 72'h1);
        check("pause_not_idle", 72'(idle), 72'h0);
        expq.push_back(72'hE0); expq.push_back(72'hE1); expq.push_back(72'hE2);
        req = 1'b0;
        tick();
        @(negedge clk);
        check("release_ack", 72'(ack), 72'h0);
        check("release_wr_t1", 72'(desc_wr), 72'h0);
        tick();
        @(negedge clk);
        check("release_wr_t2", 72'(desc_wr), 72'h1);
        repeat (6) tick();
        check("release_drained", 72'(expq.size()), 72'h0);

        // Drop counter saturation while paused with all FIFOs full
        do_reset();
        req = 1'b1;
        set_ports(4'b1111, 8'h40);
        repeat (4) tick();
        @(negedge clk);
        check("sat_fill_drop", 72'(drop_cnt), 72'h0);
        tick();
        @(negedge clk);
        check("sat_first4", 72'(drop_cnt), 72'h4);
        repeat (16382) tick();
        @(negedge clk);
        check("sat_fffc", 72'(drop_cnt), 72'hFFFC);
        set_ports(4'b0011, 8'h40);
        tick();
        set_ports(4'b0000, 8'h00);
        @(negedge clk);
        check("sat_fffe", 72'(drop_cnt), 72'hFFFE);
        set_ports(4'b1111, 8'h50);
        tick();
        @(negedge clk);
        check("sat_clamp", 72'(drop_cnt), 72'hFFFF);
        tick();
        set_ports(4'b0000, 8'h00);
        @(negedge clk);
        check("sat_hold", 72'(drop_cnt), 72'hFFFF);
        check("sat_ack", 72'(ack), 72'h1);

        // Reset while FIFOs hold data; nothing stale may emerge afterwards
        rst_n = 1'b0;
        #1;
        check("midrst_wr", 72'(desc_wr), 72'h0);
        check("midrst_ack", 72'(ack), 72'h0);
        check("midrst_drop", 72'(drop_cnt), 72'h0);
        check("midrst_idle", 72'(idle), 72'h1);
        req = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        repeat (10) tick();
        check("postrst_idle", 72'(idle), 72'h1);
        check("postrst_drop", 72'(drop_cnt), 72'h0);

        mon_en = 1'b0;
        check("final_queue_empty", 72'(expq.size()), 72'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
